wordline_decoder: RTL and testbench
===================================

WORDLINE_DECODER -- requirements
Module: wordline_decoder

Interface
REQ-001 Parameter ADDR_W, default 4, address width; legal range 1..8.
REQ-002 Parameter PULSE_LEN, default 2, cycles each output line is held high; legal range 1..255.
REQ-003 Derived local parameter OUT_W = 2**ADDR_W, output line count.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request carries a valid address.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_addr  input  ADDR_W  address to decode.
REQ-009 in_par  input  1  even-parity bit over in_addr; present only with ADDR_PARITY_EN.
REQ-010 scan_start  input  1  single-cycle request to sweep all lines.
REQ-011 y  output  OUT_W  registered one-hot line select; all-zero when idle.
REQ-012 busy  output  1  high in DRIVE and GAP.
REQ-013 scan_done  output  1  one-cycle pulse when a sweep completes.
REQ-014 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-015 The FSM SHALL have three states: IDLE, DRIVE and GAP.
REQ-016 in_ready SHALL equal (state==IDLE) & !scan_start & rst_n.
REQ-017 Handshake: a request is accepted at edge T when in_valid & in_ready are both high; in_addr is latched at T.
REQ-018 After acceptance at T: DRIVE for cycles T+1..T+PULSE_LEN with y = 1<<addr; GAP at T+PULSE_LEN+1 with y=0; IDLE at T+PULSE_LEN+2. Minimum request period is PULSE_LEN+2 cycles.
REQ-019 y SHALL be a flop output, exactly one-hot in DRIVE and all-zero in IDLE and GAP; no glitches on any other bit.
REQ-020 A PULSE_LEN-range hold counter SHALL load at DRIVE entry and leave DRIVE when it reaches PULSE_LEN.
REQ-021 scan_start sampled high in IDLE at edge T starts a sweep: an internal pointer is set to 0 and DRIVE is entered at T+1.
REQ-022 During a sweep, each GAP with pointer != OUT_W-1 SHALL increment the pointer and re-enter DRIVE; the GAP with pointer == OUT_W-1 SHALL return to IDLE.
REQ-023 scan_done SHALL be high for exactly the first IDLE cycle after the final GAP, which is edge T+OUT_W*(PULSE_LEN+1)+1.
REQ-024 scan_start and in_valid are ignored outside IDLE; a held in_valid is accepted on the first in_ready cycle.
REQ-025 If scan_start and in_valid are both high in IDLE, the scan wins and no handshake occurs (in_ready is low).
REQ-026 Pointer and address arithmetic is ADDR_W bits wide, with no wrap beyond OUT_W-1.

Reset
REQ-027 While rst_n is low, independent of clk: state=IDLE; y=0; busy=0; scan_done=0; err=0; in_ready=0; counter and pointer=0.
REQ-028 Reset asserted mid-DRIVE or mid-sweep SHALL abort immediately; there is no resume and no scan_done.
REQ-029 in_ready SHALL rise in the cycle rst_n is sampled high, provided scan_start is low.

Configuration
REQ-030 Macro ADDR_PARITY_EN defined: the in_par port exists. A handshake where ^{in_addr,in_par} is 1 is consumed; err pulses at T+1, the state stays IDLE and y stays 0.
REQ-031 Macro ADDR_PARITY_EN undefined: there is no in_par port, err is tied 0, and all other behaviour is identical.

Verification (ADDR_W=4, PULSE_LEN=2)
REQ-032 Single request: accept in_addr=4'hA at T -> y=16'h0400 at T+1 and T+2, y=0 at T+3, in_ready=1 at T+4, busy=1 during T+1..T+3.
REQ-033 Exhaustive addresses: in_valid held, addresses 0..15 back-to-back -> each y is 1<<addr, accepts spaced exactly 4 cycles apart, no y cycle with more than one bit set.
REQ-034 Sweep: scan_start at T -> y=16'h0001 at T+1..T+2, 16'h0002 at T+4..T+5, ..., 16'h8000 at T+46..T+47; scan_done=1 only at T+49.
REQ-035 Priority: scan_start and in_valid(addr 3) in the same IDLE cycle -> sweep runs, in_ready=0 throughout; addr 3 is accepted at T+49, giving y=16'h0008 at T+50.
REQ-036 Reset mid-operation: rst_n low while y=16'h0020 -> y=0, busy=0 and in_ready=0 with no clock edge; rst_n high -> in_ready=1 that cycle.
REQ-037 Parity (ADDR_PARITY_EN defined): in_addr=4'h1 with in_par=0 -> err=1 at T+1 only, y=0, in_ready=1 at T+1; in_par=1 -> normal decode with y=16'h0002.

Source files
------------

// File: rtl/wordline_decoder_if.sv
// rtl/wordline_decoder_if.sv - request handshake bundle for wordline_decoder (in_par only with ADDR_PARITY_EN)
interface wordline_decoder_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
`ifdef ADDR_PARITY_EN
  logic              in_par;

  modport master (output in_valid, output in_addr, output in_par, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_par, output in_ready);
`else
  modport master (output in_valid, output in_addr, input in_ready);
  modport slave  (input in_valid, input in_addr, output in_ready);
`endif
endinterface

// File: rtl/wordline_decoder.sv
// rtl/wordline_decoder.sv - pulsed one-hot wordline decoder with sweep mode; ADDR_PARITY_EN adds request parity check
module wordline_decoder #(
  parameter  int ADDR_W    = 4,
  parameter  int PULSE_LEN = 2,
  localparam int OUT_W     = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  wordline_decoder_if.slave   bus,
  input  logic                scan_start,
  output logic [OUT_W-1:0]    y,
  output logic                busy,
  output logic                scan_done,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [7:0]        cnt;
  logic [7:0]        cnt_d;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_d;
  logic              sweep;
  logic              sweep_d;
  logic [OUT_W-1:0]  y_d;
  logic              done_d;
  logic              accept;
  logic              addr_ok;
  logic              last_line;
  logic              hold_done;

  // The scan request steals the IDLE cycle, so it masks the handshake.
  assign bus.in_ready = (state == IDLE) & ~scan_start & rst_n;
  assign accept       = bus.in_valid & bus.in_ready;
  assign last_line    = (ptr == {ADDR_W{1'b1}});
  assign hold_done    = (cnt == 8'(PULSE_LEN));
  assign busy         = (state != IDLE);

`ifdef ADDR_PARITY_EN
  logic err_d;
  logic err_q;
  assign addr_ok = ~^{bus.in_addr, bus.in_par};
  assign err     = err_q;
`else
  assign addr_ok = 1'b1;
  assign err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state: sweep wins over a request; a sweep loops GAP->DRIVE until the last line.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (scan_start) begin
          state_d = DRIVE;
        end else if (accept && addr_ok) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_done) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (sweep && !last_line) begin
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; y is computed from the next line so it can be a clean flop.
  always_comb begin
    cnt_d   = cnt;
    ptr_d   = ptr;
    sweep_d = sweep;
    done_d  = 1'b0;
`ifdef ADDR_PARITY_EN
    err_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (scan_start) begin
          ptr_d   = '0;
          sweep_d = 1'b1;
          cnt_d   = 8'd1;
        end else if (accept) begin
          if (addr_ok) begin
            ptr_d   = bus.in_addr;
            sweep_d = 1'b0;
            cnt_d   = 8'd1;
          end
`ifdef ADDR_PARITY_EN
          else begin
            err_d = 1'b1;
          end
`endif
        end
      end
      DRIVE: begin
        if (!hold_done) begin
          cnt_d = cnt + 8'd1;
        end
      end
      GAP: begin
        if (sweep && !last_line) begin
          ptr_d = ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
          cnt_d = 8'd1;
        end else begin
          done_d  = sweep;
          sweep_d = 1'b0;
        end
      end
      default: begin
        sweep_d = 1'b0;
      end
    endcase
    y_d = (state_d == DRIVE) ? (OUT_W'(1) << ptr_d) : '0;
  end

  // Registered datapath and outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 8'd0;
      ptr       <= '0;
      sweep     <= 1'b0;
      y         <= '0;
      scan_done <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      ptr       <= ptr_d;
      sweep     <= sweep_d;
      y         <= y_d;
      scan_done <= done_d;
    end
  end

`ifdef ADDR_PARITY_EN
  // One-cycle error pulse for a request rejected on parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_wordline_decoder.sv
// tb/tb_wordline_decoder.sv - self-checking bench for wordline_decoder (ADDR_W=4, PULSE_LEN=2)
module tb_wordline_decoder;

  localparam int AW = 4;
  localparam int PL = 2;
  localparam int NW = 16;

  typedef struct packed {
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic        err;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_start = 1'b0;
  logic        tb_par = 1'b0;
  logic [15:0] y;
  logic        busy;
  logic        scan_done;
  logic        err;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   dut_acc = 0;
  ent_t q[$];
  ent_t cur = '0;

  wordline_decoder_if #(.ADDR_W(AW)) bus ();

`ifdef ADDR_PARITY_EN
  assign bus.in_par = tb_par;
`endif

  wordline_decoder #(.ADDR_W(AW), .PULSE_LEN(PL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .scan_start (scan_start),
    .y          (y),
    .busy       (busy),
    .scan_done  (scan_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic bit par_ok(input logic [3:0] a);
`ifdef ADDR_PARITY_EN
    return (^{a, tb_par}) == 1'b0;
`else
    return a[0] | ~a[0];
`endif
  endfunction

  task automatic set_addr(input logic [3:0] a);
    bus.in_addr = a;
    tb_par = ^a;
  endtask

  // One clock: check handshake, advance the reference schedule, check registered outputs.
  task automatic tick();
    ent_t nxt;
    logic rdy_exp;
    #1;
    rdy_exp = rst_n && !cur.busy && !scan_start;
    checks++;
    if (bus.in_ready !== rdy_exp) begin
      errors++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, rdy_exp);
    end
    dut_acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    if (dut_acc) acc_cyc = cyc;
    if (!rst_n) begin
      q.delete();
    end else if (!cur.busy && scan_start) begin
      for (int i = 0; i < NW; i++) begin
        for (int k = 0; k < PL; k++) q.push_back({16'h1 << i, 1'b1, 1'b0, 1'b0});
        q.push_back({16'h0, 1'b1, 1'b0, 1'b0});
      end
      q.push_back({16'h0, 1'b0, 1'b1, 1'b0});
    end else if (rdy_exp && bus.in_valid) begin
      if (par_ok(bus.in_addr)) begin
        for (int k = 0; k < PL; k++) q.push_back({16'h1 << bus.in_addr, 1'b1, 1'b0, 1'b0});
        q.push_back({16'h0, 1'b1, 1'b0, 1'b0});
      end else begin
        q.push_back({16'h0, 1'b0, 1'b0, 1'b1});
      end
    end
    nxt = (q.size() > 0) ? q.pop_front() : '0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    cur = nxt;
    checks++;
    if (y !== cur.y) begin
      errors++;
      $display("FAIL y cyc=%0d got=%h exp=%h", cyc, y, cur.y);
    end
    checks++;
    if (busy !== cur.busy) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, cur.busy);
    end
    checks++;
    if (scan_done !== cur.done) begin
      errors++;
      $display("FAIL scan_done cyc=%0d got=%b exp=%b", cyc, scan_done, cur.done);
    end
    checks++;
    if (err !== cur.err) begin
      errors++;
      $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, cur.err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    set_addr(4'h0);
    scan_start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({y, busy, scan_done, err, bus.in_ready} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state got y=%h busy=%b done=%b err=%b rdy=%b exp all 0", y, busy, scan_done, err, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready);
    end
    cur = '0;
    q.delete();
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1;
    set_addr(4'hA);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (!dut_acc || y !== 16'h0400) begin
      errors++;
      $display("FAIL single_t1 acc=%b y=%h exp acc=1 y=0400", dut_acc, y);
    end
    tick();
    checks++;
    if (y !== 16'h0400 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_t2 y=%h busy=%b exp 0400/1", y, busy);
    end
    tick();
    checks++;
    if (y !== 16'h0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_t3 y=%h busy=%b exp 0000/1", y, busy);
    end
    tick();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_t4 rdy=%b busy=%b exp 1/0", bus.in_ready, busy);
    end
  endtask

  task automatic test_exhaustive();
    int nxt_a = 0;
    int prev = -1;
    int budget = 0;
    bus.in_valid = 1'b1;
    set_addr(4'h0);
    while (nxt_a < NW && budget < 200) begin
      tick();
      budget++;
      checks++;
      if ($countones(y) > 1) begin
        errors++;
        $display("FAIL onehot cyc=%0d y=%h", cyc, y);
      end
      if (dut_acc) begin
        if (prev >= 0) begin
          checks++;
          if (acc_cyc - prev !== PL + 2) begin
            errors++;
            $display("FAIL accept_spacing got=%0d exp=%0d", acc_cyc - prev, PL + 2);
          end
        end
        prev = acc_cyc;
        nxt_a++;
        set_addr(4'(nxt_a));
      end
    end
    checks++;
    if (nxt_a != NW) begin
      errors++;
      $display("FAIL exhaustive_timeout accepted=%0d exp=%0d", nxt_a, NW);
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_sweep();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int j = 1; j <= 49; j++) begin
      if (j == 1 || j == 4 || j == 46 || j == 47) begin
        checks++;
        if (y !== (16'h1 << ((j - 1) / 3))) begin
          errors++;
          $display("FAIL sweep_line j=%0d got=%h exp=%h", j, y, 16'h1 << ((j - 1) / 3));
        end
      end
      checks++;
      if (scan_done !== (j == 49)) begin
        errors++;
        $display("FAIL sweep_done j=%0d got=%b exp=%b", j, scan_done, j == 49);
      end
      if (j < 49) tick();
    end
    tick();
  endtask

  task automatic test_priority();
    bus.in_valid = 1'b1;
    set_addr(4'h3);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    checks++;
    if (dut_acc || y !== 16'h0001) begin
      errors++;
      $display("FAIL prio_start acc=%b y=%h exp acc=0 y=0001", dut_acc, y);
    end
    for (int j = 1; j <= 49; j++) begin
      #1;
      checks++;
      if (bus.in_ready !== (j == 49)) begin
        errors++;
        $display("FAIL prio_ready j=%0d got=%b exp=%b", j, bus.in_ready, j == 49);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!dut_acc || y !== 16'h0008) begin
      errors++;
      $display("FAIL prio_accept acc=%b y=%h exp acc=1 y=0008", dut_acc, y);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    set_addr(4'h5);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (y !== 16'h0020) begin
      errors++;
      $display("FAIL mid_pre y=%h exp=0020", y);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 16'h0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_async y=%h busy=%b rdy=%b exp 0/0/0", y, busy, bus.in_ready);
    end
    cur = '0;
    q.delete();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_release_ready got=%b exp=1", bus.in_ready);
    end
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_abort y=%h busy=%b exp 0/0", y, busy);
    end
    cur = '0;
    q.delete();
    tick();
    rst_n = 1'b1;
    repeat (50) tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      set_addr(4'($urandom_range(0, 15)));
`ifdef ADDR_PARITY_EN
      if ($urandom_range(0, 7) == 0) tb_par = ~tb_par;
`endif
      scan_start = ($urandom_range(0, 24) == 0);
      tick();
    end
    bus.in_valid = 1'b0;
    scan_start = 1'b0;
    repeat (52) tick();
  endtask

`ifdef ADDR_PARITY_EN
  task automatic test_parity();
    bus.in_valid = 1'b1;
    bus.in_addr = 4'h1;
    tb_par = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || y !== 16'h0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL parity_bad err=%b y=%h rdy=%b exp 1/0000/1", err, y, bus.in_ready);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL parity_pulse err=%b exp=0", err);
    end
    bus.in_valid = 1'b1;
    tb_par = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (y !== 16'h0002 || err !== 1'b0) begin
      errors++;
      $display("FAIL parity_good y=%h err=%b exp 0002/0", y, err);
    end
    repeat (4) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_exhaustive();
    test_sweep();
    test_priority();
    test_reset_mid();
`ifdef ADDR_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
